mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control FSM for the MIPS core. It sequences the shared datapath (IFU, GRF, EXT, ALU, DM, and the A3/WD/B muxes) through FETCH/DECODE/EXEC/MEM/WB so one ALU and one memory port serve every instruction phase. It replaces the single-cycle combinational controller. Outputs drive the existing datapath select and enable codes directly.

Parameters:
MEM_LAT, 1, cycles spent in MEM per lw/sw (legal range 1..15).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], stable from the cycle after FETCH
funct  in  6  IR[5:0]
Equ  in  1  ALU equality flag, valid in EXEC
PCWr  out  1  PC register write enable
IRWr  out  1  IR load enable; the datapath also latches PC4 of the current instruction in the same cycle
NPCOp  out  2  00 PC+4, 01 branch, 10 j/jal target, 11 jr (RD1)
GRFWr  out  1  register file write enable
DMWr  out  1  data memory write enable
EXTOp  out  1  0 zero-extend, 1 sign-extend
ALUOp  out  2  00 add, 01 sub, 10 or, 11 lui (B<<16)
BSel  out  1  0 RD2, 1 Ext
A3Sel  out  2  00 rd, 01 rt, 10 $ra
WDSel  out  2  00 C, 01 D, 10 PC4, 11 imm32
state  out  3  current state, for debug
illegal  out  1  1-cycle pulse in DECODE for an unsupported encoding
instr_done  out  1  1-cycle pulse in the final state of each instruction

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Values 5–7 are unreachable; if entered, go to FETCH.
- Reset (reset=0, asynchronous): state=FETCH, mem counter=0, and every output forced to 0 while reset is low.
- Reset released: the first rising edge acts as the FETCH cycle.
- Reset asserted mid-instruction: no write enable may remain asserted. The sequence aborts and restarts at FETCH.
- Outputs are Moore (decoded from state and the latched IR fields). The one exception is PCWr in beq EXEC, which is Equ (Mealy).
- Any enable or select not listed for a state is 0.
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state is DECODE.
- DECODE: classify opcode/funct.
  - j: PCWr=1, NPCOp=10, done.
  - jal: PCWr=1, NPCOp=10, GRFWr=1, A3Sel=10, WDSel=10, done.
  - jr (op 000000, funct 001000): PCWr=1, NPCOp=11, done.
  - nop (IR fields op=0, funct=0): done.
  - Unsupported encoding: illegal=1, done; treated as nop.
  - All other instructions go to EXEC.
- EXEC:
  - addu (funct 100001): ALUOp=00, BSel=0. Next WB.
  - subu (funct 100011): ALUOp=01, BSel=0. Next WB.
  - ori (001101): ALUOp=10, BSel=1, EXTOp=0. Next WB.
  - lui (001111): ALUOp=11, BSel=1. Next WB.
  - lw (100011) / sw (101011): ALUOp=00, BSel=1, EXTOp=1. Next MEM.
  - beq (000100): ALUOp=01, BSel=0, EXTOp=1, NPCOp=01, PCWr=Equ, done.
- MEM: the ALU/EXT controls of EXEC are held stable, because the datapath keeps no address register.
  - A 4-bit counter increments each cycle; leave MEM when counter==MEM_LAT-1, then clear the counter.
  - sw: DMWr=1 only in the first MEM cycle; done in the last MEM cycle.
  - lw: next state is WB.
- WB:
  - R-type: GRFWr=1, A3Sel=00, WDSel=00, with the EXEC ALU controls held.
  - ori/lui: GRFWr=1, A3Sel=01, WDSel=00, with the EXEC ALU controls held.
  - lw: GRFWr=1, A3Sel=01, WDSel=01, with the MEM ALU/EXT controls held.
  - Done.
- "done": instr_done=1 for that cycle and the next state is FETCH.
- Cycle counts per instruction:
  - j/jal/jr/nop: 2
  - beq: 3
  - R-type/ori/lui: 4
  - sw: 3+MEM_LAT
  - lw: 4+MEM_LAT
- Exactly one PCWr pulse per FETCH. At most one additional PCWr per instruction (jump, or a taken branch).

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings
  - opcode/funct constants
  - NPCOp, ALUOp, A3Sel and WDSel code constants
  - instruction-class enum: RTYPE_ADDU, RTYPE_SUBU, ORI, LUI, LW, SW, BEQ, J, JAL, JR, NOP, ILLEGAL
- Sub-module mc_ctrl_dec: combinational opcode/funct → class decoder.
- mc_ctrl itself holds the FSM, the MEM counter and the output decode.

Test Plan:
- reset=0 held for 3 cycles, then released → all outputs 0 during reset. First cycle after release: state=0, IRWr=1, PCWr=1, NPCOp=00.
- addu (op 0, funct 100001) → states 0,1,2,4. WB cycle: GRFWr=1, A3Sel=00, WDSel=00. instr_done pulses once.
- lw with MEM_LAT=3 → states 0,1,2,3,3,3,4 (7 cycles). DMWr=0 throughout. WB: GRFWr=1, A3Sel=01, WDSel=01.
- sw with MEM_LAT=3 → DMWr=1 only in the first MEM cycle. GRFWr=0 throughout. Total 6 cycles.
- beq: Equ=1 → EXEC PCWr=1, NPCOp=01. Equ=0 → EXEC PCWr=0. Both cases take 3 cycles.
- jal → DECODE: PCWr=1, NPCOp=10, GRFWr=1, A3Sel=10, WDSel=10. Opcode 111111 → illegal=1 in DECODE, no write enables asserted. reset=0 asserted mid-MEM of sw → DMWr=0 immediately, state=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, instruction
// fields, datapath select codes and the decoded instruction class.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    RTYPE_ADDU,
    RTYPE_SUBU,
    ORI,
    LUI,
    LW,
    SW,
    BEQ,
    J,
    JAL,
    JR,
    NOP,
    ILLEGAL
  } instr_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  localparam logic [1:0] A3_RD    = 2'b00;
  localparam logic [1:0] A3_RT    = 2'b01;
  localparam logic [1:0] A3_RA    = 2'b10;

  localparam logic [1:0] WD_C     = 2'b00;
  localparam logic [1:0] WD_D     = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;
  localparam logic [1:0] WD_IMM   = 2'b11;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational opcode/funct classifier; anything not recognised is ILLEGAL.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output instr_cls_e cls
);

  always_comb begin
    cls = ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = RTYPE_ADDU;
          FN_SUBU: cls = RTYPE_SUBU;
          FN_JR:   cls = JR;
          FN_NOP:  cls = NOP;
          default: cls = ILLEGAL;
        endcase
      end
      OP_ORI:  cls = ORI;
      OP_LUI:  cls = LUI;
      OP_LW:   cls = LW;
      OP_SW:   cls = SW;
      OP_BEQ:  cls = BEQ;
      OP_J:    cls = J;
      OP_JAL:  cls = JAL;
      default: cls = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over the shared
// datapath and drives its select/enable codes (Moore, except beq PCWr = Equ).
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Equ,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] NPCOp,
  output logic       GRFWr,
  output logic       DMWr,
  output logic       EXTOp,
  output logic [1:0] ALUOp,
  output logic       BSel,
  output logic [1:0] A3Sel,
  output logic [1:0] WDSel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       instr_done
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  instr_cls_e cls;

  // ALU/EXT controls for the current class, reused unchanged in EXEC, MEM and WB
  logic [1:0] alu_op_c;
  logic       bsel_c;
  logic       ext_c;

  mc_ctrl_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    alu_op_c = ALU_ADD;
    bsel_c   = 1'b0;
    ext_c    = 1'b0;
    case (cls)
      RTYPE_SUBU: alu_op_c = ALU_SUB;
      ORI: begin
        alu_op_c = ALU_OR;
        bsel_c   = 1'b1;
      end
      LUI: begin
        alu_op_c = ALU_LUI;
        bsel_c   = 1'b1;
      end
      LW, SW: begin
        bsel_c = 1'b1;
        ext_c  = 1'b1;
      end
      BEQ: begin
        alu_op_c = ALU_SUB;
        ext_c    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    NPCOp      = NPC_PC4;
    GRFWr      = 1'b0;
    DMWr       = 1'b0;
    EXTOp      = 1'b0;
    ALUOp      = ALU_ADD;
    BSel       = 1'b0;
    A3Sel      = A3_RD;
    WDSel      = WD_C;
    illegal    = 1'b0;
    instr_done = 1'b0;
    state      = state_q;

    case (state_q)
      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        NPCOp   = NPC_PC4;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        instr_done = 1'b1;
        state_d    = S_FETCH;
        case (cls)
          J: begin
            PCWr  = 1'b1;
            NPCOp = NPC_JMP;
          end
          JAL: begin
            PCWr  = 1'b1;
            NPCOp = NPC_JMP;
            GRFWr = 1'b1;
            A3Sel = A3_RA;
            WDSel = WD_PC4;
          end
          JR: begin
            PCWr  = 1'b1;
            NPCOp = NPC_JR;
          end
          NOP: ;
          ILLEGAL: illegal = 1'b1;
          default: begin
            instr_done = 1'b0;
            state_d    = S_EXEC;
          end
        endcase
      end

      S_EXEC: begin
        ALUOp = alu_op_c;
        BSel  = bsel_c;
        EXTOp = ext_c;
        case (cls)
          RTYPE_ADDU, RTYPE_SUBU, ORI, LUI: state_d = S_WB;
          LW, SW: state_d = S_MEM;
          BEQ: begin
            NPCOp      = NPC_BR;
            PCWr       = Equ;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        ALUOp = alu_op_c;
        BSel  = bsel_c;
        EXTOp = ext_c;
        DMWr  = (cls == SW) && (cnt_q == 4'd0);
        if (cnt_q == MEM_LAST) begin
          cnt_d = '0;
          if (cls == SW) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WB: begin
        ALUOp      = alu_op_c;
        BSel       = bsel_c;
        EXTOp      = ext_c;
        GRFWr      = 1'b1;
        A3Sel      = (cls == RTYPE_ADDU || cls == RTYPE_SUBU) ? A3_RD : A3_RT;
        WDSel      = (cls == LW) ? WD_D : WD_C;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // Reset low must silence every output at once, not just at the next edge
    if (!reset) begin
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      NPCOp      = '0;
      GRFWr      = 1'b0;
      DMWr       = 1'b0;
      EXTOp      = 1'b0;
      ALUOp      = '0;
      BSel       = 1'b0;
      A3Sel      = '0;
      WDSel      = '0;
      illegal    = 1'b0;
      instr_done = 1'b0;
      state      = '0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction's expected per-cycle output
// sequence is built from the controller's documented behaviour and compared.
module tb_mc_ctrl;

  localparam int MEM_LAT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Equ;
  logic       PCWr, IRWr, GRFWr, DMWr, EXTOp, BSel, illegal, instr_done;
  logic [1:0] NPCOp, ALUOp, A3Sel, WDSel;
  logic [2:0] state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                    K_J, K_JAL, K_JR, K_NOP, K_ILL} kind_e;

  mc_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .Equ        (Equ),
    .PCWr       (PCWr),
    .IRWr       (IRWr),
    .NPCOp      (NPCOp),
    .GRFWr      (GRFWr),
    .DMWr       (DMWr),
    .EXTOp      (EXTOp),
    .ALUOp      (ALUOp),
    .BSel       (BSel),
    .A3Sel      (A3Sel),
    .WDSel      (WDSel),
    .state      (state),
    .illegal    (illegal),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Packed view: state,PCWr,IRWr,NPCOp,GRFWr,DMWr,EXTOp,ALUOp,BSel,A3Sel,WDSel,illegal,instr_done
  function automatic logic [31:0] dut_vec();
    return {13'd0, state, PCWr, IRWr, NPCOp, GRFWr, DMWr, EXTOp, ALUOp,
            BSel, A3Sel, WDSel, illegal, instr_done};
  endfunction

  function automatic logic [31:0] v(int st, bit pcwr, bit irwr, int npc, bit grf, bit dm,
                                    bit ext, int alu, bit bsel, int a3, int wd, bit ill, bit done);
    return {13'd0, 3'(st), pcwr, irwr, 2'(npc), grf, dm, ext, 2'(alu),
            bsel, 2'(a3), 2'(wd), ill, done};
  endfunction

  function automatic bit legal_enc(logic [5:0] op, logic [5:0] fn);
    if (op == 6'b000000) return fn inside {6'b100001, 6'b100011, 6'b001000, 6'b000000};
    return op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011,
                      6'b000100, 6'b000010, 6'b000011};
  endfunction

  task automatic encode(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (k)
      K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      K_ORI:  op = 6'b001101;
      K_LUI:  op = 6'b001111;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      K_JR:   begin op = 6'b000000; fn = 6'b001000; end
      K_NOP:  begin op = 6'b000000; fn = 6'b000000; end
      default: begin
        op = ($urandom_range(0, 1) == 0) ? 6'b000000 : 6'($urandom);
        while (legal_enc(op, fn)) fn = 6'($urandom);
      end
    endcase
  endtask

  // Expected cycle-by-cycle outputs for one instruction, FETCH through its done cycle
  task automatic build(input kind_e k, input bit eq, output logic [31:0] q[$]);
    int alu, a3, wd;
    bit bsel, ext, is_sw;
    q = {};
    q.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (k)
      K_J:   q.push_back(v(1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      K_JAL: q.push_back(v(1, 1, 0, 2, 1, 0, 0, 0, 0, 2, 2, 0, 1));
      K_JR:  q.push_back(v(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      K_NOP: q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      K_ILL: q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      default: begin
        q.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        alu = 0; bsel = 0; ext = 0;
        case (k)
          K_SUBU: alu = 1;
          K_ORI:  begin alu = 2; bsel = 1; end
          K_LUI:  begin alu = 3; bsel = 1; end
          K_LW, K_SW: begin bsel = 1; ext = 1; end
          K_BEQ:  begin alu = 1; ext = 1; end
          default: ;
        endcase
        is_sw = (k == K_SW);
        if (k == K_BEQ) begin
          q.push_back(v(2, eq, 0, 1, 0, 0, ext, alu, bsel, 0, 0, 0, 1));
        end else begin
          q.push_back(v(2, 0, 0, 0, 0, 0, ext, alu, bsel, 0, 0, 0, 0));
          if (k == K_LW || k == K_SW)
            for (int i = 0; i < MEM_LAT; i++)
              q.push_back(v(3, 0, 0, 0, 0, is_sw && i == 0, ext, alu, bsel, 0, 0, 0,
                            is_sw && i == MEM_LAT - 1));
          if (!is_sw) begin
            a3 = (k == K_ADDU || k == K_SUBU) ? 0 : 1;
            wd = (k == K_LW) ? 1 : 0;
            q.push_back(v(4, 0, 0, 0, 1, 0, ext, alu, bsel, a3, wd, 0, 1));
          end
        end
      end
    endcase
  endtask

  // Called at a falling edge inside FETCH; returns at the falling edge of the next FETCH
  task automatic run_enc(input kind_e k, input logic [5:0] op, input logic [5:0] fn,
                         input bit eq, input string name);
    logic [31:0] q[$];
    build(k, eq, q);
    opcode = op; funct = fn; Equ = eq;
    foreach (q[i]) begin
      #1;
      chk($sformatf("%s_c%0d", name, i), dut_vec(), q[i]);
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input kind_e k, input bit eq, input string name);
    logic [5:0] op, fn;
    encode(k, op, fn);
    run_enc(k, op, fn, eq, name);
  endtask

  initial begin
    kind_e k;
    reset = 1'b0; opcode = '0; funct = '0; Equ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      opcode = 6'($urandom); Equ = 1'($urandom);
      chk($sformatf("reset_c%0d", i), dut_vec(), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    run_instr(K_ADDU, 1'b0, "addu");
    run_instr(K_LW,   1'b0, "lw");
    run_instr(K_SW,   1'b1, "sw");
    run_instr(K_BEQ,  1'b1, "beq_taken");
    run_instr(K_BEQ,  1'b0, "beq_not");
    run_instr(K_JAL,  1'b0, "jal");
    run_instr(K_J,    1'b0, "j");
    run_instr(K_JR,   1'b0, "jr");
    run_instr(K_NOP,  1'b0, "nop");
    run_enc(K_ILL, 6'b111111, 6'($urandom), 1'b0, "ill_op3f");
    run_instr(K_SUBU, 1'b0, "subu");
    run_instr(K_ORI,  1'b0, "ori");
    run_instr(K_LUI,  1'b0, "lui");

    for (int n = 0; n < 80; n++) begin
      k = kind_e'($urandom_range(0, 11));
      run_instr(k, 1'($urandom), $sformatf("rnd%0d", n));
    end

    // Abort a sw in its second MEM cycle, then prove a clean restart
    opcode = 6'b101011; funct = 6'($urandom); Equ = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    chk("abort_mem1_dmwr", 32'(DMWr), 32'd1);
    @(negedge clk); #1;
    chk("abort_mem2_state", 32'(state), 32'd3);
    reset = 1'b0;
    #1;
    chk("abort_outputs_zero", dut_vec(), 32'd0);
    @(negedge clk); #1;
    chk("abort_hold_zero", dut_vec(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_instr(K_SW, 1'b0, "sw_after_abort");
    run_instr(K_LW, 1'b0, "lw_after_abort");

    for (int n = 0; n < 20; n++) begin
      k = kind_e'($urandom_range(0, 11));
      run_instr(k, 1'($urandom), $sformatf("rndb%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
